// File: rtl/instruction_fetch_stage.sv
// RV32I fetch stage: owns the PC, talks to instruction memory over a valid/ready
// handshake, and drives the IF/ID pipeline register for decode.
module instruction_fetch_stage #(
    parameter int                     WORD_LENGTH        = 32,
    parameter int                     ADDRESS_PORT_WIDTH = 5,
    parameter int                     OPCODE_SIZE        = 7,
    parameter logic [WORD_LENGTH-1:0] RESET_PC           = 32'h0000_0000
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic                          EN,
    input  logic                          HazardDetected,
    input  logic                          BranchTaken,
    input  logic                          Jump,
    input  logic                          JumpReg,
    input  logic [WORD_LENGTH-1:0]        ImmediateOutputforPC,
    input  logic [WORD_LENGTH-1:0]        dataA,
    output logic                          imem_req,
    output logic [WORD_LENGTH-1:0]        imem_addr,
    input  logic                          imem_valid,
    input  logic [WORD_LENGTH-1:0]        imem_rdata,
    output logic [WORD_LENGTH-1:0]        previousPC,
    output logic [WORD_LENGTH-1:0]        ReadInstruction,
    output logic [OPCODE_SIZE-1:0]        prevOpcode,
    output logic [ADDRESS_PORT_WIDTH-1:0] prevReadReg1,
    output logic [ADDRESS_PORT_WIDTH-1:0] prevReadReg2,
    output logic                          IF_ID_Valid
);

    localparam logic [WORD_LENGTH-1:0] NOP_INSTR = WORD_LENGTH'(32'h0000_0013);
    localparam logic [WORD_LENGTH-1:0] PC_STEP   = WORD_LENGTH'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_KILL = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    fetch_state_t           state;
    logic [WORD_LENGTH-1:0] pc;
    logic [WORD_LENGTH-1:0] pend_pc;
    logic [WORD_LENGTH-1:0] hold_buf;

    logic                   stall;
    logic                   redirect;
    logic                   transfer;
    logic [WORD_LENGTH-1:0] target_base;
    logic [WORD_LENGTH-1:0] target_sum;
    logic [WORD_LENGTH-1:0] target;

    logic                   ifid_load;
    logic [WORD_LENGTH-1:0] ifid_pc;
    logic [WORD_LENGTH-1:0] ifid_word;
    logic                   ifid_valid;

    // Redirects are suppressed while stalled because ID operands are not yet valid.
    assign stall     = HazardDetected || !EN;
    assign redirect  = (BranchTaken || Jump || JumpReg) && !stall;
    assign imem_req  = (state != S_HOLD);
    assign imem_addr = pc;
    assign transfer  = imem_req && imem_valid;

    // Clearing [1:0] covers both the JALR bit-0 clear and the forced word alignment.
    assign target_base = JumpReg ? dataA : previousPC;
    assign target_sum  = target_base + ImmediateOutputforPC;
    assign target      = {target_sum[WORD_LENGTH-1:2], 2'b00};

    always_comb begin
        ifid_load  = 1'b0;
        ifid_pc    = previousPC;
        ifid_word  = NOP_INSTR;
        ifid_valid = 1'b0;
        unique case (state)
            S_REQ: begin
                if (redirect) begin
                    ifid_load = 1'b1;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    if (transfer) begin
                        ifid_pc    = pc;
                        ifid_word  = imem_rdata;
                        ifid_valid = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    ifid_load = 1'b1;
                end else if (!stall) begin
                    ifid_load  = 1'b1;
                    ifid_pc    = pc;
                    ifid_word  = hold_buf;
                    ifid_valid = 1'b1;
                end
            end
            default: begin
                ifid_load = 1'b0;
            end
        endcase
    end

    // S_KILL keeps requesting the abandoned address so the single outstanding
    // response is consumed and dropped before the new PC is issued.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state           <= S_REQ;
            pc              <= RESET_PC;
            pend_pc         <= RESET_PC;
            hold_buf        <= '0;
            previousPC      <= '0;
            ReadInstruction <= NOP_INSTR;
            prevOpcode      <= NOP_INSTR[OPCODE_SIZE-1:0];
            prevReadReg1    <= '0;
            prevReadReg2    <= '0;
            IF_ID_Valid     <= 1'b0;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (transfer) begin
                        if (redirect) begin
                            pc <= target;
                        end else if (stall) begin
                            hold_buf <= imem_rdata;
                            state    <= S_HOLD;
                        end else begin
                            pc <= pc + PC_STEP;
                        end
                    end else if (redirect) begin
                        pend_pc <= target;
                        state   <= S_KILL;
                    end
                end
                S_KILL: begin
                    if (transfer) begin
                        pc    <= redirect ? target : pend_pc;
                        state <= S_REQ;
                    end else if (redirect) begin
                        pend_pc <= target;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        hold_buf <= '0;
                        pc       <= target;
                        state    <= S_REQ;
                    end else if (!stall) begin
                        pc    <= pc + PC_STEP;
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase

            if (ifid_load) begin
                previousPC      <= ifid_pc;
                ReadInstruction <= ifid_word;
                prevOpcode      <= ifid_word[OPCODE_SIZE-1:0];
                prevReadReg1    <= ifid_word[15 +: ADDRESS_PORT_WIDTH];
                prevReadReg2    <= ifid_word[20 +: ADDRESS_PORT_WIDTH];
                IF_ID_Valid     <= ifid_valid;
            end
        end
    end

endmodule
